simple_bus_resp: RTL and testbench

// Bus responder (target side) of the simple req/ack bus that the dvv driver and monitor

---
 rtl/simple_bus_resp.sv | 164 ++++++++++++++++
 tb/tb_simple_bus_resp.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/simple_bus_resp.sv
// simple_bus_resp
//   Target side of the simple req/ack bus. Accepts one read or write at a
//   time, inserts WAIT_CYC wait states, then answers from a DEPTH-word
//   register array with a one-cycle ack strobe. Misaligned or out-of-range
//   addresses complete with err=1 and leave the array untouched.
//
// Ports
//   clk      in   1         rising-edge clock
//   rst      in   1         synchronous reset, active high
//   req      in   1         request valid, held by the initiator until ack
//   we       in   1         1 = write, 0 = read
//   addr     in   ADDR_W    byte address (word aligned)
//   wd       in   DATA_W    write data
//   be       in   DATA_W/8  write byte enables
//   ack      out  1         one-cycle response strobe
//   rd       out  DATA_W    read data, zero outside the ack cycle
//   err      out  1         error flag, zero outside the ack cycle
//   busy     out  1         high from acceptance through the ack cycle
//   txn_cnt  out  16        completed transactions, wraps at 16 bits
module simple_bus_resp #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 16,
  parameter int WAIT_CYC = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wd,
  input  logic [DATA_W/8-1:0]   be,
  output logic                  ack,
  output logic [DATA_W-1:0]     rd,
  output logic                  err,
  output logic                  busy,
  output logic [15:0]           txn_cnt
);

  localparam int NB     = DATA_W / 8;
  localparam int IDX_W  = ADDR_W - 2;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WC_W   = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
  localparam logic [WC_W-1:0] WC_LAST = WC_W'((WAIT_CYC > 0) ? WAIT_CYC - 1 : 0);
  localparam logic [IDX_W:0]  DEPTH_L = (IDX_W + 1)'(DEPTH);
  localparam logic            NO_WAIT = (WAIT_CYC == 0);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;

  logic [1:0]          r_state;
  logic [WC_W-1:0]     r_wcnt;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wd;
  logic [NB-1:0]       r_be;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [DATA_W-1:0]   r_rd;
  logic                r_err;
  logic [15:0]         r_txn_cnt;

  logic                w_we;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_wd;
  logic [NB-1:0]       w_be;
  logic [IDX_W-1:0]    w_idx;
  logic [MEM_AW-1:0]   w_mi;
  logic                w_err;
  logic                w_enter_ack;
  logic                w_accept;

  // With zero wait states the array is accessed on the accepting edge itself,
  // before the latched copies exist, so the live request fields are used in
  // IDLE and the latched ones everywhere else.
  always_comb begin
    w_we   = r_we;
    w_addr = r_addr;
    w_wd   = r_wd;
    w_be   = r_be;
    if (r_state == S_IDLE) begin
      w_we   = we;
      w_addr = addr;
      w_wd   = wd;
      w_be   = be;
    end
  end

  assign w_idx       = w_addr[ADDR_W-1:2];
  assign w_mi        = w_idx[MEM_AW-1:0];
  assign w_err       = (w_addr[1:0] != 2'b00) || ({1'b0, w_idx} >= DEPTH_L);
  assign w_accept    = (r_state == S_IDLE) && req;
  assign w_enter_ack = (w_accept && NO_WAIT) ||
                       ((r_state == S_WAIT) && (r_wcnt == WC_LAST));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_wcnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_state <= NO_WAIT ? S_ACK : S_WAIT;
            r_wcnt  <= '0;
          end
        end
        S_WAIT: begin
          if (r_wcnt == WC_LAST) r_state <= S_ACK;
          else                   r_wcnt  <= r_wcnt + WC_W'(1);
        end
        S_ACK:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Request fields are captured once; the initiator may change them freely
  // after acceptance.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_we   <= we;
      r_addr <= addr;
      r_wd   <= wd;
      r_be   <= be;
    end
  end

  // Array update and read capture both happen on the edge entering ACK.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_enter_ack && w_we && !w_err) begin
      for (int b = 0; b < NB; b++) begin
        if (w_be[b]) r_mem[w_mi][b*8 +: 8] <= w_wd[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd  <= '0;
      r_err <= 1'b0;
    end else if (w_enter_ack) begin
      r_err <= w_err;
      r_rd  <= (!w_we && !w_err) ? r_mem[w_mi] : '0;
    end else begin
      r_rd  <= '0;
      r_err <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                    r_txn_cnt <= '0;
    else if (r_state == S_ACK)  r_txn_cnt <= r_txn_cnt + 16'd1;
  end

  assign ack     = (r_state == S_ACK);
  assign busy    = (r_state != S_IDLE);
  assign rd      = r_rd;
  assign err     = r_err;
  assign txn_cnt = r_txn_cnt;

endmodule

// File: tb/tb_simple_bus_resp.sv
// tb_simple_bus_resp
//   Directed bench for simple_bus_resp (WAIT_CYC=2). Expected {err, rd}
//   pairs are queued as requests are issued and popped by a monitor on
//   every ack; latency, busy and txn_cnt are checked inline.
module tb_simple_bus_resp;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int WC     = 2;

  logic        clk  = 1'b0;
  logic        rst  = 1'b1;
  logic        req  = 1'b0;
  logic        we   = 1'b0;
  logic [7:0]  addr = '0;
  logic [31:0] wd   = '0;
  logic [3:0]  be   = '0;
  logic        ack;
  logic [31:0] rd;
  logic        err;
  logic        busy;
  logic [15:0] txn_cnt;

  simple_bus_resp #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .WAIT_CYC(WC)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .we     (we),
    .addr   (addr),
    .wd     (wd),
    .be     (be),
    .ack    (ack),
    .rd     (rd),
    .err    (err),
    .busy   (busy),
    .txn_cnt(txn_cnt)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_mis = 0;
  logic [32:0] exp_q[$];
  logic [15:0] exp_cnt = 16'd0;
  logic [32:0] mon_e;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: each ack must match the oldest outstanding expectation;
  // outside ack, rd and err must be zero.
  always @(negedge clk) begin
    if (ack === 1'b1) begin
      chk("sb_pending", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk("sb_rd", 64'(rd), 64'(mon_e[31:0]));
        chk("sb_err", 64'(err), 64'(mon_e[32]));
      end
    end else begin
      chk("idle_rd_err", 64'({rd, err}), 64'd0);
    end
  end

  // One complete transaction; request fields are scrambled after acceptance.
  task automatic txn(input string tag, input logic t_we, input logic [7:0] t_addr,
                     input logic [31:0] t_wd, input logic [3:0] t_be,
                     input logic [31:0] e_rd, input logic e_err);
    int k;
    exp_q.push_back({e_err, e_rd});
    req  = 1'b1;
    we   = t_we;
    addr = t_addr;
    wd   = t_wd;
    be   = t_be;
    @(posedge clk); #1;
    k = 1;
    chk({tag, "_busy_acc"}, 64'(busy), 64'd1);
    we   = ~t_we;
    addr = t_addr ^ 8'hFF;
    wd   = ~t_wd;
    be   = ~t_be;
    while (ack !== 1'b1 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk({tag, "_latency"}, 64'(k), 64'(WC + 1));
    chk({tag, "_busy_ack"}, 64'(busy), 64'd1);
    req = 1'b0;
    @(posedge clk); #1;
    exp_cnt = exp_cnt + 16'd1;
    chk({tag, "_busy_idle"}, 64'(busy), 64'd0);
    chk({tag, "_cnt"}, 64'(txn_cnt), 64'(exp_cnt));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int last;
    int n_ack;
    int n_idle;

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", 64'(ack), 64'd0);
    chk("rst_rd", 64'(rd), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_cnt", 64'(txn_cnt), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Read after reset
    txn("rd04", 1'b0, 8'h04, 32'h0, 4'h0, 32'h0, 1'b0);

    // Full and partial writes, zero byte-enable write
    txn("wr08_full", 1'b1, 8'h08, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
    txn("rd08_a",    1'b0, 8'h08, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);
    txn("wr08_part", 1'b1, 8'h08, 32'h11223344, 4'b0101, 32'h0, 1'b0);
    txn("rd08_b",    1'b0, 8'h08, 32'h0, 4'h0, 32'hDE22BE44, 1'b0);
    txn("wr08_be0",  1'b1, 8'h08, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0);
    txn("rd08_c",    1'b0, 8'h08, 32'h0, 4'h0, 32'hDE22BE44, 1'b0);
    txn("wr3c",      1'b1, 8'h3C, 32'h0BADCAFE, 4'hF, 32'h0, 1'b0);
    txn("rd3c",      1'b0, 8'h3C, 32'h0, 4'h0, 32'h0BADCAFE, 1'b0);

    // Error addresses: no memory change, rd=0, counter still advances
    txn("wr40_err",  1'b1, 8'h40, 32'hCAFEF00D, 4'hF, 32'h0, 1'b1);
    txn("wr09_err",  1'b1, 8'h09, 32'h55555555, 4'hF, 32'h0, 1'b1);
    txn("rd41_err",  1'b0, 8'h41, 32'h0, 4'h0, 32'h0, 1'b1);
    txn("rd40_err",  1'b0, 8'h40, 32'h0, 4'h0, 32'h0, 1'b1);
    txn("rd00_alias", 1'b0, 8'h00, 32'h0, 4'h0, 32'h0, 1'b0);
    txn("rd08_d",    1'b0, 8'h08, 32'h0, 4'h0, 32'hDE22BE44, 1'b0);

    // Back-to-back reads with req held high
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, 32'hDE22BE44});
    req    = 1'b1;
    we     = 1'b0;
    addr   = 8'h08;
    wd     = 32'h0;
    be     = 4'h0;
    n_ack  = 0;
    n_idle = 0;
    k      = 0;
    last   = 0;
    while (n_ack < 4 && k < 40) begin
      @(posedge clk); #1;
      k++;
      if (busy !== 1'b1) n_idle++;
      if (ack === 1'b1) begin
        if (n_ack > 0) chk("b2b_spacing", 64'(k - last), 64'(WC + 2));
        last = k;
        n_ack++;
      end
    end
    req = 1'b0;
    chk("b2b_acks", 64'(n_ack), 64'd4);
    chk("b2b_idle_cycles", 64'(n_idle), 64'd3);
    @(posedge clk); #1;
    exp_cnt = exp_cnt + 16'd4;
    chk("b2b_cnt", 64'(txn_cnt), 64'(exp_cnt));
    chk("b2b_busy_end", 64'(busy), 64'd0);

    // Reset during the wait phase of a write
    req  = 1'b1;
    we   = 1'b1;
    addr = 8'h0C;
    wd   = 32'hA5A5A5A5;
    be   = 4'hF;
    @(posedge clk); #1;
    chk("abort_busy_wait", 64'(busy), 64'd1);
    rst = 1'b1;
    req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_cnt = 16'd0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_ack", 64'(ack), 64'd0);
    chk("abort_cnt", 64'(txn_cnt), 64'd0);
    n_ack = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (ack === 1'b1) n_ack++;
    end
    chk("abort_no_ack", 64'(n_ack), 64'd0);
    txn("rd0c_after_abort", 1'b0, 8'h0C, 32'h0, 4'h0, 32'h0, 1'b0);
    txn("rd08_after_rst",   1'b0, 8'h08, 32'h0, 4'h0, 32'h0, 1'b0);

    // Counter wrap from 0xFFFF
    force dut.r_txn_cnt = 16'hFFFF;
    #2;
    release dut.r_txn_cnt;
    #1;
    chk("wrap_preload", 64'(txn_cnt), 64'hFFFF);
    exp_cnt = 16'hFFFF;
    txn("wrap", 1'b0, 8'h04, 32'h0, 4'h0, 32'h0, 1'b0);
    chk("wrap_zero", 64'(txn_cnt), 64'h0);

    repeat (2) @(posedge clk);
    #1;
    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
